// File: rtl/game_mode_control.sv
// +--------------------------------------------------------------------------+
// | Module   : game_mode_control                                             |
// | Purpose  : Game-mode sequencer. Walks the datapath through the init and  |
// |            menu screens, the scrolling-note pipeline (load, update, RAM  |
// |            writes, shifts, four lane draws, frame delay), the error      |
// |            flash/redraw and the battle timeout. It also owns the x/y and |
// |            colour source muxes so only one datapath source drives VGA.   |
// | Ports    : clk, reset (async, active-low)                                |
// |            key_valid/key_code      - decoded PS/2 key strobe + code      |
// |            frame_done, finish_*    - datapath completion strobes         |
// |            color, clear, timer     - error checker / error / battle time |
// |            init/menu/casual/battle - background image select             |
// |            restart*, load, update, shift*, wren*, delay, draw*           |
// |                                    - datapath controls (registered)      |
// |            display_select*, color_select*                                |
// |                                    - 0 background, 1 scroll, 2 error     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_mode_control #(
  parameter logic [7:0] KEY_START  = 8'h5A,
  parameter logic [7:0] KEY_CASUAL = 8'h16,
  parameter logic [7:0] KEY_BATTLE = 8'h1E,
  parameter logic [7:0] KEY_ESC    = 8'h76
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       frame_done,
  input  logic       finish_update,
  input  logic       finish_draw1,
  input  logic       finish_draw2,
  input  logic       finish_draw3,
  input  logic       finish_draw4,
  input  logic       finish_error,
  input  logic       finish_delay,
  input  logic       color,
  input  logic       clear,
  input  logic       timer,
  output logic       init,
  output logic       menu,
  output logic       casual,
  output logic       battle,
  output logic       restart,
  output logic       restart_scroll,
  output logic       restart_error,
  output logic       load,
  output logic       update,
  output logic       shift1,
  output logic       shift2,
  output logic       shift3,
  output logic       wren1,
  output logic       wren2,
  output logic       wren3,
  output logic       wren4,
  output logic       delay,
  output logic       draw1,
  output logic       draw2,
  output logic       draw3,
  output logic       draw4,
  output logic       draw_error,
  output logic       redraw_error,
  output logic [2:0] display_select,
  output logic [2:0] display_select_scroll,
  output logic [2:0] display_select_error,
  output logic [2:0] color_select,
  output logic [2:0] color_select_scroll,
  output logic [2:0] color_select_error
);

  // Ordering matters: the scroll loop, error path and play states are
  // contiguous so range compares can classify the state.
  typedef enum logic [4:0] {
    S_INIT_RST   = 5'd0,
    S_INIT_DRAW  = 5'd1,
    S_INIT_WAIT  = 5'd2,
    S_MENU_RST   = 5'd3,
    S_MENU_DRAW  = 5'd4,
    S_MENU_WAIT  = 5'd5,
    S_PLAY_RST   = 5'd6,
    S_PLAY_BG    = 5'd7,
    S_LOAD       = 5'd8,
    S_UPDATE     = 5'd9,
    S_WR1        = 5'd10,
    S_WR2        = 5'd11,
    S_WR3        = 5'd12,
    S_WR4        = 5'd13,
    S_SH1        = 5'd14,
    S_SH2        = 5'd15,
    S_SH3        = 5'd16,
    S_DRAW1      = 5'd17,
    S_DRAW2      = 5'd18,
    S_DRAW3      = 5'd19,
    S_DRAW4      = 5'd20,
    S_DELAY      = 5'd21,
    S_ERR_RST    = 5'd22,
    S_ERR_DRAW   = 5'd23,
    S_ERR_HOLD   = 5'd24,
    S_ERR_REDRAW = 5'd25,
    S_OVER       = 5'd26
  } state_t;

  state_t     state_q, state_d;
  logic       key_pend_q, key_pend_d;
  logic       mode_battle_q, mode_battle_d;

  logic       init_q, menu_q, casual_q, battle_q;
  logic       restart_q, restart_scroll_q, restart_error_q;
  logic       load_q, update_q, delay_q;
  logic [2:0] shift_q;
  logic [3:0] wren_q;
  logic [3:0] draw_q;
  logic       draw_error_q, redraw_error_q;
  logic [2:0] sel_q;

  logic w_esc, w_start, w_in_loop, w_in_err, w_in_play, w_d_active;

  assign w_esc     = key_valid && (key_code == KEY_ESC);
  assign w_start   = key_valid && (key_code == KEY_START);
  assign w_in_loop = (state_q >= S_LOAD) && (state_q <= S_DELAY);
  assign w_in_err  = (state_q >= S_ERR_RST) && (state_q <= S_ERR_REDRAW);
  assign w_in_play = (state_q >= S_PLAY_RST);
  // A pending key only lives while the game stays in the loop/error region.
  assign w_d_active = (state_d >= S_LOAD) && (state_d <= S_ERR_REDRAW);

  always_comb begin
    state_d       = state_q;
    key_pend_d    = key_pend_q;
    mode_battle_d = mode_battle_q;

    if (w_in_loop && key_valid) begin
      key_pend_d = 1'b1;
    end

    case (state_q)
      S_INIT_RST:   state_d = S_INIT_DRAW;
      S_INIT_DRAW:  if (frame_done) state_d = S_INIT_WAIT;
      S_INIT_WAIT:  if (w_start) state_d = S_MENU_RST;
      S_MENU_RST:   state_d = S_MENU_DRAW;
      S_MENU_DRAW:  if (frame_done) state_d = S_MENU_WAIT;
      S_MENU_WAIT: begin
        if (key_valid && (key_code == KEY_CASUAL)) begin
          mode_battle_d = 1'b0;
          state_d       = S_PLAY_RST;
        end else if (key_valid && (key_code == KEY_BATTLE)) begin
          mode_battle_d = 1'b1;
          state_d       = S_PLAY_RST;
        end
      end
      S_PLAY_RST:   state_d = S_PLAY_BG;
      S_PLAY_BG:    if (frame_done) state_d = S_LOAD;
      S_LOAD:       state_d = S_UPDATE;
      S_UPDATE:     if (finish_update) state_d = S_WR1;
      S_WR1:        state_d = S_WR2;
      S_WR2:        state_d = S_WR3;
      S_WR3:        state_d = S_WR4;
      S_WR4:        state_d = S_SH1;
      S_SH1:        state_d = S_SH2;
      S_SH2:        state_d = S_SH3;
      S_SH3:        state_d = S_DRAW1;
      S_DRAW1:      if (finish_draw1) state_d = S_DRAW2;
      S_DRAW2:      if (finish_draw2) state_d = S_DRAW3;
      S_DRAW3:      if (finish_draw3) state_d = S_DRAW4;
      S_DRAW4:      if (finish_draw4) state_d = S_DELAY;
      S_DELAY: begin
        // Timeout outranks the error decision.
        if (mode_battle_q && timer) begin
          state_d = S_OVER;
        end else if (finish_delay) begin
          if (key_pend_q && color) begin
            state_d = S_ERR_RST;
          end else begin
            state_d    = S_LOAD;
            // The serviced key is dropped; a key arriving on this very
            // cycle belongs to the next scroll step.
            key_pend_d = key_valid;
          end
        end
      end
      S_ERR_RST:    state_d = S_ERR_DRAW;
      S_ERR_DRAW:   if (finish_error) state_d = S_ERR_HOLD;
      S_ERR_HOLD: begin
        if (mode_battle_q && timer) begin
          state_d = S_OVER;
        end else if (clear) begin
          state_d = S_ERR_REDRAW;
        end
      end
      S_ERR_REDRAW: begin
        if (finish_error) begin
          state_d    = S_LOAD;
          key_pend_d = 1'b0;
        end
      end
      S_OVER:       if (w_esc || w_start) state_d = S_MENU_RST;
      default:      state_d = S_INIT_RST;
    endcase

    // Escape pre-empts everything while playing, including a pending error.
    if (w_esc && (w_in_loop || w_in_err || (state_q == S_PLAY_BG))) begin
      state_d = S_MENU_RST;
    end

    if (!w_d_active) begin
      key_pend_d = 1'b0;
    end
  end

  // State plus Moore outputs; outputs are decoded from the current state
  // and therefore trail state entry by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_INIT_RST;
      key_pend_q       <= 1'b0;
      mode_battle_q    <= 1'b0;
      init_q           <= 1'b1;
      menu_q           <= 1'b0;
      casual_q         <= 1'b0;
      battle_q         <= 1'b0;
      restart_q        <= 1'b0;
      restart_scroll_q <= 1'b0;
      restart_error_q  <= 1'b0;
      load_q           <= 1'b0;
      update_q         <= 1'b0;
      delay_q          <= 1'b0;
      shift_q          <= 3'd0;
      wren_q           <= 4'd0;
      draw_q           <= 4'd0;
      draw_error_q     <= 1'b0;
      redraw_error_q   <= 1'b0;
      sel_q            <= 3'd0;
    end else begin
      state_q          <= state_d;
      key_pend_q       <= key_pend_d;
      mode_battle_q    <= mode_battle_d;
      init_q           <= (state_q <= S_INIT_WAIT);
      menu_q           <= (state_q >= S_MENU_RST) && (state_q <= S_MENU_WAIT);
      casual_q         <= w_in_play && !mode_battle_q;
      battle_q         <= w_in_play && mode_battle_q;
      restart_q        <= (state_q == S_INIT_RST) || (state_q == S_MENU_RST) ||
                          (state_q == S_PLAY_RST);
      restart_scroll_q <= (state_q == S_PLAY_RST);
      restart_error_q  <= (state_q == S_PLAY_RST) || (state_q == S_ERR_RST);
      load_q           <= (state_q == S_LOAD);
      update_q         <= (state_q == S_UPDATE);
      delay_q          <= (state_q == S_DELAY);
      shift_q          <= {state_q == S_SH3, state_q == S_SH2, state_q == S_SH1};
      wren_q           <= {state_q == S_WR4, state_q == S_WR3,
                           state_q == S_WR2, state_q == S_WR1};
      draw_q           <= {state_q == S_DRAW4, state_q == S_DRAW3,
                           state_q == S_DRAW2, state_q == S_DRAW1};
      draw_error_q     <= (state_q == S_ERR_DRAW);
      redraw_error_q   <= (state_q == S_ERR_REDRAW);
      // ERR_RST keeps the background source; the error colour takes over
      // only once the flash is being drawn.
      if (w_in_loop) begin
        sel_q <= 3'd1;
      end else if (w_in_err && (state_q != S_ERR_RST)) begin
        sel_q <= 3'd2;
      end else begin
        sel_q <= 3'd0;
      end
    end
  end

  assign init                  = init_q;
  assign menu                  = menu_q;
  assign casual                = casual_q;
  assign battle                = battle_q;
  assign restart               = restart_q;
  assign restart_scroll        = restart_scroll_q;
  assign restart_error         = restart_error_q;
  assign load                  = load_q;
  assign update                = update_q;
  assign shift1                = shift_q[0];
  assign shift2                = shift_q[1];
  assign shift3                = shift_q[2];
  assign wren1                 = wren_q[0];
  assign wren2                 = wren_q[1];
  assign wren3                 = wren_q[2];
  assign wren4                 = wren_q[3];
  assign delay                 = delay_q;
  assign draw1                 = draw_q[0];
  assign draw2                 = draw_q[1];
  assign draw3                 = draw_q[2];
  assign draw4                 = draw_q[3];
  assign draw_error            = draw_error_q;
  assign redraw_error          = redraw_error_q;
  assign display_select        = sel_q;
  assign display_select_scroll = sel_q;
  assign display_select_error  = sel_q;
  assign color_select          = sel_q;
  assign color_select_scroll   = sel_q;
  assign color_select_error    = sel_q;

  a_one_draw: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({draw_q, draw_error_q, redraw_error_q}));
  a_one_bg: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({init_q, menu_q, casual_q, battle_q}));

endmodule

`default_nettype wire

// File: tb/tb_game_mode_control.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_game_mode_control                                          |
// | Purpose  : Self-checking bench for game_mode_control. Each vector names   |
// |            the state the controller occupies while its inputs are shown; |
// |            the outputs of that state are expected after the next edge.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_game_mode_control;

  localparam logic [7:0] KS = 8'h5A;
  localparam logic [7:0] KC = 8'h16;
  localparam logic [7:0] KB = 8'h1E;
  localparam logic [7:0] KE = 8'h76;
  localparam logic [7:0] KX = 8'h1C;

  // finish strobe bits: {delay, error, draw4, draw3, draw2, draw1, update}
  localparam logic [6:0] F_UPD = 7'h01;
  localparam logic [6:0] F_D1  = 7'h02;
  localparam logic [6:0] F_ERR = 7'h20;
  localparam logic [6:0] F_DLY = 7'h40;

  typedef enum int {
    E_RSTV, E_INIT_RST, E_INIT_DRAW, E_INIT_WAIT, E_MENU_RST, E_MENU_DRAW,
    E_MENU_WAIT, E_PLAY_RST, E_PLAY_BG, E_LOAD, E_UPDATE, E_WR1, E_WR2, E_WR3,
    E_WR4, E_SH1, E_SH2, E_SH3, E_DRAW1, E_DRAW2, E_DRAW3, E_DRAW4, E_DELAY,
    E_ERR_RST, E_ERR_DRAW, E_ERR_HOLD, E_ERR_REDRAW, E_OVER
  } ecode_t;

  typedef struct packed {
    logic       init, menu, casual, battle;
    logic       restart, restart_scroll, restart_error;
    logic       load, update;
    logic [2:0] shift;
    logic [3:0] wren;
    logic       delay;
    logic [3:0] draw;
    logic       draw_error, redraw_error;
    logic [2:0] ds, dss, dse, cs, css, cse;
  } ov_t;

  typedef struct {
    ecode_t     e;
    logic       m;
    logic       rn;
    logic       kv;
    logic [7:0] kc;
    logic       fd;
    logic [6:0] fin;
    logic       col, clr, tmr;
  } vec_t;

  typedef struct {
    int     idx;
    ecode_t e;
    ov_t    exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic frame_done = 1'b0;
  logic finish_update = 1'b0, finish_draw1 = 1'b0, finish_draw2 = 1'b0;
  logic finish_draw3 = 1'b0, finish_draw4 = 1'b0, finish_error = 1'b0;
  logic finish_delay = 1'b0;
  logic color = 1'b0, clear = 1'b0, timer = 1'b0;
  logic init, menu, casual, battle, restart, restart_scroll, restart_error;
  logic load, update, shift1, shift2, shift3, wren1, wren2, wren3, wren4;
  logic delay, draw1, draw2, draw3, draw4, draw_error, redraw_error;
  logic [2:0] display_select, display_select_scroll, display_select_error;
  logic [2:0] color_select, color_select_scroll, color_select_error;

  ov_t  act;
  vec_t tbl[$];
  sb_t  sb[$];
  sb_t  cur;
  logic bm = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vidx = 0;

  always #5 clk = ~clk;

  game_mode_control dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .frame_done(frame_done), .finish_update(finish_update),
    .finish_draw1(finish_draw1), .finish_draw2(finish_draw2),
    .finish_draw3(finish_draw3), .finish_draw4(finish_draw4),
    .finish_error(finish_error), .finish_delay(finish_delay),
    .color(color), .clear(clear), .timer(timer),
    .init(init), .menu(menu), .casual(casual), .battle(battle),
    .restart(restart), .restart_scroll(restart_scroll),
    .restart_error(restart_error), .load(load), .update(update),
    .shift1(shift1), .shift2(shift2), .shift3(shift3),
    .wren1(wren1), .wren2(wren2), .wren3(wren3), .wren4(wren4),
    .delay(delay), .draw1(draw1), .draw2(draw2), .draw3(draw3), .draw4(draw4),
    .draw_error(draw_error), .redraw_error(redraw_error),
    .display_select(display_select), .display_select_scroll(display_select_scroll),
    .display_select_error(display_select_error), .color_select(color_select),
    .color_select_scroll(color_select_scroll), .color_select_error(color_select_error)
  );

  assign act = {init, menu, casual, battle, restart, restart_scroll, restart_error,
                load, update, shift3, shift2, shift1, wren4, wren3, wren2, wren1,
                delay, draw4, draw3, draw2, draw1, draw_error, redraw_error,
                display_select, display_select_scroll, display_select_error,
                color_select, color_select_scroll, color_select_error};

  // Expected outputs of a state, straight from the output table of the design.
  function automatic ov_t exp_out(ecode_t e, logic m);
    ov_t o;
    logic [2:0] s;
    o = '0;
    s = 3'd0;
    case (e)
      E_RSTV:       o.init = 1'b1;
      E_INIT_RST:   begin o.init = 1'b1; o.restart = 1'b1; end
      E_INIT_DRAW, E_INIT_WAIT: o.init = 1'b1;
      E_MENU_RST:   begin o.menu = 1'b1; o.restart = 1'b1; end
      E_MENU_DRAW, E_MENU_WAIT: o.menu = 1'b1;
      E_PLAY_RST:   begin o.restart = 1'b1; o.restart_scroll = 1'b1; o.restart_error = 1'b1; end
      E_LOAD:       begin o.load = 1'b1; s = 3'd1; end
      E_UPDATE:     begin o.update = 1'b1; s = 3'd1; end
      E_WR1:        begin o.wren[0] = 1'b1; s = 3'd1; end
      E_WR2:        begin o.wren[1] = 1'b1; s = 3'd1; end
      E_WR3:        begin o.wren[2] = 1'b1; s = 3'd1; end
      E_WR4:        begin o.wren[3] = 1'b1; s = 3'd1; end
      E_SH1:        begin o.shift[0] = 1'b1; s = 3'd1; end
      E_SH2:        begin o.shift[1] = 1'b1; s = 3'd1; end
      E_SH3:        begin o.shift[2] = 1'b1; s = 3'd1; end
      E_DRAW1:      begin o.draw[0] = 1'b1; s = 3'd1; end
      E_DRAW2:      begin o.draw[1] = 1'b1; s = 3'd1; end
      E_DRAW3:      begin o.draw[2] = 1'b1; s = 3'd1; end
      E_DRAW4:      begin o.draw[3] = 1'b1; s = 3'd1; end
      E_DELAY:      begin o.delay = 1'b1; s = 3'd1; end
      E_ERR_RST:    o.restart_error = 1'b1;
      E_ERR_DRAW:   begin o.draw_error = 1'b1; s = 3'd2; end
      E_ERR_HOLD:   s = 3'd2;
      E_ERR_REDRAW: begin o.redraw_error = 1'b1; s = 3'd2; end
      default:      o = '0;
    endcase
    if (e >= E_PLAY_RST) begin
      o.casual = !m;
      o.battle = m;
    end
    o.ds = s; o.dss = s; o.dse = s; o.cs = s; o.css = s; o.cse = s;
    return o;
  endfunction

  function automatic vec_t mk(ecode_t e, logic [6:0] fin = 7'd0, logic fd = 1'b0,
                              logic kv = 1'b0, logic [7:0] kc = 8'h00,
                              logic col = 1'b0, logic clr = 1'b0,
                              logic tmr = 1'b0, logic rn = 1'b1);
    vec_t v;
    v.e = e; v.m = bm; v.rn = rn; v.kv = kv; v.kc = kc; v.fd = fd;
    v.fin = fin; v.col = col; v.clr = clr; v.tmr = tmr;
    return v;
  endfunction

  // LOAD through DRAW4; every waiting state gets its finish on its lat-th cycle.
  function automatic void body(int lat, bit key_d2, logic [6:0] ld_fin);
    tbl.push_back(mk(E_LOAD, ld_fin));
    for (int i = 0; i < lat; i++)
      tbl.push_back(mk(E_UPDATE, (i == lat - 1) ? F_UPD : 7'd0));
    for (int w = 0; w < 4; w++) tbl.push_back(mk(ecode_t'(int'(E_WR1) + w)));
    for (int s = 0; s < 3; s++) tbl.push_back(mk(ecode_t'(int'(E_SH1) + s)));
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < lat; i++)
        tbl.push_back(mk(ecode_t'(int'(E_DRAW1) + d),
                         (i == lat - 1) ? 7'(F_D1 << d) : 7'd0, 1'b0,
                         key_d2 && (d == 1) && (i == 0), KX));
  endfunction

  task automatic drv(input vec_t v);
    sb_t s;
    @(negedge clk);
    reset      = v.rn;
    key_valid  = v.kv;
    key_code   = v.kc;
    frame_done = v.fd;
    {finish_delay, finish_error, finish_draw4, finish_draw3, finish_draw2,
     finish_draw1, finish_update} = v.fin;
    color = v.col; clear = v.clr; timer = v.tmr;
    s.idx = vidx; s.e = v.e; s.exp = exp_out(v.e, v.m);
    sb.push_back(s);
    vidx++;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL vec%0d %s: got %h want %h", cur.idx, cur.e.name(), act, cur.exp);
      end
    end
  end

  initial begin
    // Reset values, init screen, menu, battle selection.
    tbl.push_back(mk(E_RSTV, 7'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(E_RSTV, 7'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(E_INIT_RST));
    tbl.push_back(mk(E_INIT_DRAW));
    tbl.push_back(mk(E_INIT_DRAW, 7'd0, 1'b1));
    tbl.push_back(mk(E_INIT_WAIT, 7'd0, 1'b0, 1'b1, KB));
    tbl.push_back(mk(E_INIT_WAIT, 7'd0, 1'b0, 1'b1, KS));
    tbl.push_back(mk(E_MENU_RST));
    tbl.push_back(mk(E_MENU_DRAW, 7'd0, 1'b1));
    tbl.push_back(mk(E_MENU_WAIT, 7'd0, 1'b0, 1'b1, KS));
    tbl.push_back(mk(E_MENU_WAIT, 7'd0, 1'b0, 1'b1, KB));
    bm = 1'b1;
    tbl.push_back(mk(E_PLAY_RST));
    tbl.push_back(mk(E_PLAY_BG));
    tbl.push_back(mk(E_PLAY_BG, 7'd0, 1'b1));
    // Full loop, finishes after 3 cycles, no key.
    body(3, 1'b0, 7'd0);
    for (int i = 0; i < 3; i++) tbl.push_back(mk(E_DELAY, (i == 2) ? F_DLY : 7'd0));
    // Mismatched key during DRAW2 -> error flash after the loop.
    body(1, 1'b1, 7'd0);
    tbl.push_back(mk(E_DELAY, F_DLY, 1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mk(E_ERR_RST));
    tbl.push_back(mk(E_ERR_DRAW));
    tbl.push_back(mk(E_ERR_DRAW, F_ERR));
    tbl.push_back(mk(E_ERR_HOLD));
    tbl.push_back(mk(E_ERR_HOLD, 7'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(E_ERR_REDRAW));
    tbl.push_back(mk(E_ERR_REDRAW, F_ERR));
    // Pending key was cleared, so color alone must not raise an error.
    body(1, 1'b0, 7'd0);
    tbl.push_back(mk(E_DELAY, F_DLY, 1'b0, 1'b0, 8'h00, 1'b1));
    // Timer beats a mismatched key in battle mode.
    body(1, 1'b1, 7'd0);
    tbl.push_back(mk(E_DELAY, F_DLY, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(E_OVER, 7'd0, 1'b0, 1'b1, KC));
    tbl.push_back(mk(E_OVER));
    tbl.push_back(mk(E_OVER, 7'd0, 1'b0, 1'b1, KS));
    tbl.push_back(mk(E_MENU_RST));
    tbl.push_back(mk(E_MENU_DRAW, 7'd0, 1'b1));
    tbl.push_back(mk(E_MENU_WAIT, 7'd0, 1'b0, 1'b1, KC));
    bm = 1'b0;
    tbl.push_back(mk(E_PLAY_RST));
    tbl.push_back(mk(E_PLAY_BG, 7'd0, 1'b1));
    // Casual: stray finish_update in LOAD ignored; timer ignored; ESC in hold.
    body(2, 1'b1, F_UPD);
    tbl.push_back(mk(E_DELAY, F_DLY, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(E_ERR_RST));
    tbl.push_back(mk(E_ERR_DRAW, F_ERR));
    tbl.push_back(mk(E_ERR_HOLD, 7'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(E_ERR_HOLD, 7'd0, 1'b0, 1'b1, KE, 1'b1, 1'b1));
    tbl.push_back(mk(E_MENU_RST));

    foreach (tbl[i]) drv(tbl[i]);

    // Hand sequence: reset asserted for two cycles while parked in DRAW3.
    drv(mk(E_MENU_DRAW, 7'd0, 1'b1));
    drv(mk(E_MENU_WAIT, 7'd0, 1'b0, 1'b1, KC));
    drv(mk(E_PLAY_RST));
    drv(mk(E_PLAY_BG, 7'd0, 1'b1));
    drv(mk(E_LOAD));
    drv(mk(E_UPDATE, F_UPD));
    for (int w = 0; w < 4; w++) drv(mk(ecode_t'(int'(E_WR1) + w)));
    for (int s = 0; s < 3; s++) drv(mk(ecode_t'(int'(E_SH1) + s)));
    drv(mk(E_DRAW1, F_D1));
    drv(mk(E_DRAW2, 7'h04));
    drv(mk(E_DRAW3));
    drv(mk(E_DRAW3));
    drv(mk(E_RSTV, 7'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(mk(E_RSTV, 7'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(mk(E_INIT_RST));
    drv(mk(E_INIT_DRAW, 7'd0, 1'b1));
    drv(mk(E_INIT_WAIT));

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_mode_control.md
Name: game_mode_control

Overview:
- FSM controller that sequences the game-mode datapath: menu/mode screen loads, the scrolling-note pipeline (load, update, RAM writes, shifts, per-lane draws, frame delay), error flash/redraw, and the battle timeout.
- It also drives the display/colour select muxes so exactly one datapath source owns the VGA x/y/colour at a time.
- Sits between the PS/2 key decoder and the game-mode datapath; one instance per game.

Parameters:
- KEY_START, 8'h5A, scancode that leaves the init screen (Enter)
- KEY_CASUAL, 8'h16, menu scancode selecting casual mode ('1')
- KEY_BATTLE, 8'h1E, menu scancode selecting battle mode ('2')
- KEY_ESC, 8'h76, scancode returning to menu from any play/over state

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  decoded scancode
- frame_done  in  1  background image copy complete (datapath finish)
- finish_update, finish_draw1..4, finish_error, finish_delay  in  1 each  datapath done strobes
- color  in  1  error checker: 1 = last key mismatched
- clear  in  1  error display time elapsed
- timer  in  1  battle time expired (level)
- init, menu, casual, battle  out  1 each  background image select, one-hot or all 0
- restart, restart_scroll, restart_error  out  1 each  one-cycle datapath restarts
- load, update, shift1..3, wren1..4, delay  out  1 each  scroll pipeline controls
- draw1..4, draw_error, redraw_error  out  1 each  draw enables
- display_select, display_select_scroll, display_select_error  out  3 each  x/y source mux
- color_select, color_select_scroll, color_select_error  out  3 each  colour source mux

Behaviour:
- Reset (reset=0, asynchronous): state=INIT_RST; all 1-bit outputs 0 except init=1; all selects 3'd0. Reset mid-operation aborts everything; no pending strobe survives.
- Moore outputs, registered; each state's outputs appear the cycle after entry.
- Select encodings, fixed:
  - 3'd0 = background counter/image.
  - 3'd1 = scroll (text_draw x/y, q1..q4 colour).
  - 3'd2 = error_color.
  - The *_scroll and *_error variants carry the same value as the base select.
- INIT_RST: restart=1 for 1 cycle -> INIT_DRAW (init=1) until frame_done -> INIT_WAIT.
- INIT_WAIT: key_valid & key_code==KEY_START -> MENU_RST. Other keys are ignored.
- MENU_RST/MENU_DRAW/MENU_WAIT: same pattern with menu=1.
  - KEY_CASUAL or KEY_BATTLE latches mode_battle (0/1) -> PLAY_RST.
  - Other keys are ignored.
- PLAY_RST: restart, restart_scroll, restart_error all pulse 1 cycle; casual or battle=1 per mode_battle, held until MENU. -> PLAY_BG until frame_done.
- Scroll loop, display_select=1 from LOAD to DELAY:
  - LOAD: load 1 cycle.
  - UPDATE: held until finish_update.
  - WR1..WR4: wrenN 1 cycle each.
  - SH1..SH3: shiftN 1 cycle each.
  - DRAW1..DRAW4: drawN held until finish_drawN.
  - DELAY: delay held until finish_delay, then -> LOAD.
  - One loop = one scroll step.
- Key handling in loop states: key_valid is captured into key_pend (1 deep). A later key before service overwrites it.
  - Serviced at DELAY exit: color=1 -> ERR_RST; else key_pend cleared, -> LOAD.
  - KEY_ESC is serviced immediately from any loop/error state -> MENU_RST, with priority over error.
- Error path:
  - ERR_RST: restart_error 1 cycle.
  - ERR_DRAW: draw_error until finish_error; selects=2.
  - ERR_HOLD: until clear.
  - ERR_REDRAW: redraw_error until finish_error.
  - Then -> LOAD, key_pend cleared.
- Battle timeout: in battle mode, timer=1 is sampled in DELAY or ERR_HOLD -> OVER. Checked before the error decision, so timer wins over color.
  - OVER: all strobes 0, selects 0, battle=1 held.
  - KEY_ESC or KEY_START -> MENU_RST.
  - timer is ignored in casual mode.
- A finish strobe arriving in a non-waiting state is ignored. A finish strobe on the entry cycle of its waiting state is honoured; minimum state dwell is 1 cycle.
- At most one of draw1..4/draw_error/redraw_error is 1 in any cycle (checked by an assertion). At most one of init/menu/casual/battle is 1.

Test Plan:
- Reset during DRAW3 (reset low 2 cycles) -> next cycle init=1, draw3=0, selects 0; restart pulses once after release.
- Enter, frame_done, '2', frame_done -> battle=1 and restart/restart_scroll/restart_error each high exactly 1 cycle, then load one cycle.
- One loop with all finish strobes returned after 3 cycles -> exact strobe order: load, update, wren1..4, shift1..3, draw1..4, delay, then load again; display_select=1 throughout.
- Key with color=1 during DRAW2 -> loop completes, then restart_error, draw_error (select 2) until finish_error, hold until clear, redraw_error, back to LOAD.
- Battle mode: timer=1 and color=1 in DELAY -> OVER, not ERR; Enter -> menu=1.
- ESC during ERR_HOLD in casual -> MENU_RST next state, menu=1, casual=0.
